// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl: start/stop frame controller driving an external sipo shifter.
// Define SIPO_CTRL_PARITY_EN to add an even-parity bit between data and stop.
module sipo_rx_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   output logic             sipo_shift,
   input  logic [WIDTH-1:0] sipo_pout,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun,
   output logic             parity_err
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      PARITY,
      STOP
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             fe_q, fe_d;
   logic             ov_q, ov_d;
`ifdef SIPO_CTRL_PARITY_EN
   logic             pe_q, pe_d;
   logic             par_bad_q, par_bad_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      fe_d    = 1'b0;
      ov_d    = 1'b0;
`ifdef SIPO_CTRL_PARITY_EN
      pe_d      = 1'b0;
      par_bad_d = par_bad_q;
`endif
      if (valid_q && data_ready)
         valid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!sin) begin
               state_d = SHIFT;
               cnt_d   = '0;
`ifdef SIPO_CTRL_PARITY_EN
               par_bad_d = 1'b0;
`endif
            end
         end
         SHIFT: begin
            // hold the counter on the last bit so it never wraps in-frame
            if (cnt_q == LAST) begin
`ifdef SIPO_CTRL_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PARITY: begin
`ifdef SIPO_CTRL_PARITY_EN
            par_bad_d = (^sipo_pout) ^ sin;
`endif
            state_d = STOP;
         end
         STOP: begin
            state_d = IDLE;
            if (!sin) begin
               fe_d = 1'b1;
            end
`ifdef SIPO_CTRL_PARITY_EN
            else if (par_bad_q) begin
               pe_d = 1'b1;
            end
`endif
            else if (!valid_q || data_ready) begin
               data_d  = sipo_pout;
               valid_d = 1'b1;
            end else begin
               ov_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
`ifdef SIPO_CTRL_PARITY_EN
         pe_q      <= 1'b0;
         par_bad_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
`ifdef SIPO_CTRL_PARITY_EN
         pe_q      <= pe_d;
         par_bad_q <= par_bad_d;
`endif
      end
   end

   assign sipo_shift = (state_q == SHIFT);
   assign busy       = (state_q != IDLE);
   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign frame_err  = fe_q;
   assign overrun    = ov_q;
`ifdef SIPO_CTRL_PARITY_EN
   assign parity_err = pe_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// tb_sipo_rx_ctrl: scenario tasks plus a delivery scoreboard for sipo_rx_ctrl.
// A behavioural sipo shifts sin into pout whenever sipo_shift is high.
module tb_sipo_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       sin;
   logic       sipo_shift;
   logic [3:0] pout;
   logic [3:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       busy;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int pe_cnt = 0;
   logic [3:0] exp_q[$];

   sipo_rx_ctrl #(.WIDTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .sin(sin),
      .sipo_shift(sipo_shift),
      .sipo_pout(pout),
      .data_out(data_out),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .busy(busy),
      .frame_err(frame_err),
      .overrun(overrun),
      .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst)
         pout <= 4'h0;
      else if (sipo_shift)
         pout <= {pout[2:0], sin};
   end

   // scoreboard: a transfer happens on the next rising edge
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
         if (parity_err) pe_cnt++;
         if (data_valid && data_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL deliver_extra: data_out=%h, no word expected", data_out);
            end else begin
               logic [3:0] e;
               e = exp_q.pop_front();
               if (data_out !== e) begin
                  errors++;
                  $display("FAIL deliver: data_out=%h expected %h", data_out, e);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic drive(input logic b);
      @(posedge clk);
      #2;
      sin = b;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b1);
   endtask

   task automatic send_data(input logic [3:0] d);
      drive(1'b0);
      for (int i = 3; i >= 0; i--)
         drive(d[i]);
`ifdef SIPO_CTRL_PARITY_EN
      drive(^d);
`endif
   endtask

   task automatic send_frame(input logic [3:0] d);
      send_data(d);
      drive(1'b1);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      sin = 1'b1;
      data_ready = 1'b0;
      #1;
      checks++;
      if ({busy, sipo_shift, data_valid, frame_err, overrun, parity_err} !== 6'b0
          || data_out !== 4'h0) begin
         errors++;
         $display("FAIL reset_init: busy=%b shift=%b valid=%b data=%h expected all 0",
                  busy, sipo_shift, data_valid, data_out);
      end
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      send_frame(4'h9);
      idle(2);
      checks++;
      if (data_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_preload: data_valid=%b expected 1", data_valid);
      end
      drive(1'b0);
      drive(1'b1);
      drive(1'b0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || data_valid !== 1'b0 || data_out !== 4'h0
          || sipo_shift !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: busy=%b valid=%b data=%h shift=%b expected 0",
                  busy, data_valid, data_out, sipo_shift);
      end
      sin = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      data_ready = 1'b1;
      exp_q.push_back(4'h6);
      send_frame(4'h6);
      idle(3);
   endtask

   task automatic test_good_frame;
      exp_q.push_back(4'hB);
      send_data(4'hB);
      drive(1'b1);
      @(negedge clk);
      checks++;
      if (data_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL good_early: valid=%b busy=%b expected 0/1", data_valid, busy);
      end
      @(negedge clk);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 4'hB || busy !== 1'b0) begin
         errors++;
         $display("FAIL good_capture: valid=%b data=%h busy=%b expected 1/b/0",
                  data_valid, data_out, busy);
      end
      @(negedge clk);
      checks++;
      if (data_valid !== 1'b0) begin
         errors++;
         $display("FAIL good_consume: data_valid=%b expected 0", data_valid);
      end
      idle(2);
   endtask

   task automatic test_frame_err;
      int fe0;
      fe0 = fe_cnt;
      send_data(4'h6);
      drive(1'b0);
      @(negedge clk);
      checks++;
      if (frame_err !== 1'b0) begin
         errors++;
         $display("FAIL ferr_early: frame_err=%b expected 0", frame_err);
      end
      drive(1'b1);
      @(negedge clk);
      checks++;
      if (frame_err !== 1'b1 || data_valid !== 1'b0) begin
         errors++;
         $display("FAIL ferr_pulse: frame_err=%b valid=%b expected 1/0",
                  frame_err, data_valid);
      end
      idle(3);
      checks++;
      if (fe_cnt - fe0 != 1 || data_valid !== 1'b0) begin
         errors++;
         $display("FAIL ferr_count: pulses=%0d valid=%b expected 1/0",
                  fe_cnt - fe0, data_valid);
      end
   endtask

   task automatic test_overrun;
      int ov0;
      ov0 = ov_cnt;
      drive(1'b1);
      data_ready = 1'b0;
      exp_q.push_back(4'h3);
      send_frame(4'h3);
      idle(1);
      send_frame(4'hC);
      idle(2);
      checks++;
      if (ov_cnt - ov0 != 1 || data_out !== 4'h3 || data_valid !== 1'b1) begin
         errors++;
         $display("FAIL overrun: pulses=%0d data=%h valid=%b expected 1/3/1",
                  ov_cnt - ov0, data_out, data_valid);
      end
      drive(1'b1);
      data_ready = 1'b1;
      idle(3);
      checks++;
      if (data_valid !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL overrun_drain: valid=%b pending=%0d expected 0/0",
                  data_valid, exp_q.size());
      end
   endtask

   task automatic test_simultaneous;
      int ov0;
      drive(1'b1);
      data_ready = 1'b0;
      exp_q.push_back(4'h5);
      send_frame(4'h5);
      idle(1);
      ov0 = ov_cnt;
      exp_q.push_back(4'hA);
      send_data(4'hA);
      drive(1'b1);
      data_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (data_out !== 4'hA || data_valid !== 1'b1 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL simul: data=%h valid=%b overrun=%b expected a/1/0",
                  data_out, data_valid, overrun);
      end
      idle(2);
      checks++;
      if (ov_cnt != ov0 || data_valid !== 1'b0) begin
         errors++;
         $display("FAIL simul_after: overruns=%0d valid=%b expected 0/0",
                  ov_cnt - ov0, data_valid);
      end
   endtask

   task automatic test_back_to_back;
      exp_q.push_back(4'hB);
      exp_q.push_back(4'h5);
      exp_q.push_back(4'h0);
      send_frame(4'hB);
      send_frame(4'h5);
      send_frame(4'h0);
      idle(3);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b: pending=%0d expected 0", exp_q.size());
      end
   endtask

   task automatic test_glitch;
      // a lone 0 starts a frame of all-ones data
      exp_q.push_back(4'hF);
      drive(1'b0);
      idle(8);
      checks++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch: pending=%0d busy=%b expected 0/0",
                  exp_q.size(), busy);
      end
   endtask

`ifdef SIPO_CTRL_PARITY_EN
   task automatic test_parity;
      int pe0;
      pe0 = pe_cnt;
      drive(1'b0);
      drive(1'b1);
      drive(1'b0);
      drive(1'b1);
      drive(1'b1);
      drive(1'b0);
      drive(1'b1);
      idle(3);
      checks++;
      if (pe_cnt - pe0 != 1 || data_valid !== 1'b0) begin
         errors++;
         $display("FAIL parity_bad: pulses=%0d valid=%b expected 1/0",
                  pe_cnt - pe0, data_valid);
      end
      exp_q.push_back(4'hB);
      send_frame(4'hB);
      idle(3);
      checks++;
      if (pe_cnt - pe0 != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL parity_good: pulses=%0d pending=%0d expected 1/0",
                  pe_cnt - pe0, exp_q.size());
      end
   endtask
`endif

   initial begin
      test_reset();
      test_good_frame();
      test_frame_err();
      test_overrun();
      test_simultaneous();
      test_back_to_back();
      test_glitch();
`ifdef SIPO_CTRL_PARITY_EN
      test_parity();
`endif
      idle(2);
      checks++;
      if (exp_q.size() != 0 || pe_cnt != 0 && 0) begin
         errors++;
         $display("FAIL final: pending=%0d expected 0", exp_q.size());
      end
`ifndef SIPO_CTRL_PARITY_EN
      checks++;
      if (pe_cnt != 0) begin
         errors++;
         $display("FAIL parity_tied: pulses=%0d expected 0", pe_cnt);
      end
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
